// File: rtl/pps_elapsed_timer.sv
// Elapsed-time counter disciplined by an external PPS. It keeps the sub-second count and
// the seconds count, tracks PPS lock and holdover, and timestamps per-channel capture strobes.
module pps_elapsed_timer #(
    parameter int ET_WIDTH    = 29,
    parameter int SEC_WIDTH   = 32,
    parameter int SYNC_STAGES = 2,
    parameter int PPS_MIN     = 249_000_000,
    parameter int PPS_MAX     = 251_000_000,
    parameter int NUM_CH      = 4
) (
    input  logic                          clk_250,
    input  logic                          rst,
    input  logic                          one_pps,
    input  logic [NUM_CH-1:0]             capture,
    output logic [ET_WIDTH-1:0]           elapsed_time,
    output logic [SEC_WIDTH-1:0]          seconds,
    output logic [ET_WIDTH-1:0]           pps_period,
    output logic                          pps_locked,
    output logic                          pps_missing,
    output logic                          pps_glitch,
    output logic [NUM_CH-1:0]             cap_valid,
    output logic [NUM_CH*ET_WIDTH-1:0]    cap_time,
    output logic [NUM_CH*SEC_WIDTH-1:0]   cap_sec
);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;
    localparam logic [1:0] ST_HOLDOVER = 2'd3;

    // Period checks use one extra bit so that cnt+1 never wraps before it is compared.
    localparam logic [ET_WIDTH:0]   MIN_W       = (ET_WIDTH+1)'(PPS_MIN);
    localparam logic [ET_WIDTH:0]   MAX_W       = (ET_WIDTH+1)'(PPS_MAX);
    localparam logic [ET_WIDTH-1:0] TIMEOUT_CNT = ET_WIDTH'(PPS_MAX - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   pps_prev_reg;
    logic                   pps_edge;
    logic [1:0]             state_reg, state_next;
    logic [ET_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [ET_WIDTH-1:0]    elapsed_reg;
    logic [ET_WIDTH-1:0]    period_reg, period_next;
    logic [ET_WIDTH:0]      cnt_inc;
    logic [SEC_WIDTH-1:0]   sec_reg;
    logic                   sec_inc;
    logic                   glitch_reg, glitch_next;

    assign pps_edge = sync_reg[SYNC_STAGES-1] & ~pps_prev_reg;
    assign cnt_inc  = {1'b0, cnt_reg} + (ET_WIDTH+1)'(1);

    // An edge is evaluated ahead of the timeout and wrap checks, so a coincident edge wins.
    always_comb begin
        cnt_next    = cnt_inc[ET_WIDTH-1:0];
        state_next  = state_reg;
        period_next = period_reg;
        sec_inc     = 1'b0;
        glitch_next = 1'b0;
        case (state_reg)
            ST_UNLOCKED: begin
                if (pps_edge) begin
                    cnt_next   = '0;
                    sec_inc    = 1'b1;
                    state_next = ST_ACQUIRE;
                end
            end
            ST_ACQUIRE, ST_LOCKED: begin
                if (pps_edge && (cnt_inc < MIN_W)) begin
                    glitch_next = 1'b1;
                end else if (pps_edge && (cnt_inc <= MAX_W)) begin
                    cnt_next    = '0;
                    sec_inc     = 1'b1;
                    period_next = cnt_inc[ET_WIDTH-1:0];
                    state_next  = ST_LOCKED;
                end else if (cnt_reg == TIMEOUT_CNT) begin
                    cnt_next = '0;
                    if (state_reg == ST_LOCKED) begin
                        sec_inc    = 1'b1;
                        state_next = ST_HOLDOVER;
                    end else begin
                        state_next = ST_UNLOCKED;
                    end
                end
            end
            ST_HOLDOVER: begin
                if (pps_edge) begin
                    cnt_next   = '0;
                    sec_inc    = (cnt_inc >= MIN_W);
                    state_next = ST_ACQUIRE;
                end else if (cnt_reg == period_reg - ET_WIDTH'(1)) begin
                    cnt_next = '0;
                    sec_inc  = 1'b1;
                end
            end
            default: state_next = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_250) begin
        if (rst) begin
            sync_reg     <= '0;
            pps_prev_reg <= 1'b0;
            state_reg    <= ST_UNLOCKED;
            cnt_reg      <= '0;
            elapsed_reg  <= '0;
            period_reg   <= '0;
            sec_reg      <= '0;
            glitch_reg   <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[SYNC_STAGES-2:0], one_pps};
            pps_prev_reg <= sync_reg[SYNC_STAGES-1];
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            elapsed_reg  <= cnt_reg;
            period_reg   <= period_next;
            glitch_reg   <= glitch_next;
            if (sec_inc) begin
                sec_reg <= sec_reg + SEC_WIDTH'(1);
            end
        end
    end

    assign elapsed_time = elapsed_reg;
    assign seconds      = sec_reg;
    assign pps_period   = period_reg;
    assign pps_locked   = (state_reg == ST_LOCKED);
    assign pps_missing  = (state_reg == ST_HOLDOVER);
    assign pps_glitch   = glitch_reg;

    // Captures sample the pre-load cnt and seconds, so a strobe coincident with a load sees the old values.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_cap
            logic                 cap_prev_reg;
            logic                 cap_valid_reg;
            logic [ET_WIDTH-1:0]  cap_time_reg;
            logic [SEC_WIDTH-1:0] cap_sec_reg;
            logic                 cap_rise;

            assign cap_rise = capture[gi] & ~cap_prev_reg;

            always_ff @(posedge clk_250) begin
                if (rst) begin
                    cap_prev_reg  <= 1'b0;
                    cap_valid_reg <= 1'b0;
                    cap_time_reg  <= '0;
                    cap_sec_reg   <= '0;
                end else begin
                    cap_prev_reg  <= capture[gi];
                    cap_valid_reg <= cap_rise;
                    if (cap_rise) begin
                        cap_time_reg <= cnt_reg;
                        cap_sec_reg  <= sec_reg;
                    end
                end
            end

            assign cap_valid[gi]                           = cap_valid_reg;
            assign cap_time[gi*ET_WIDTH +: ET_WIDTH]       = cap_time_reg;
            assign cap_sec[gi*SEC_WIDTH +: SEC_WIDTH]      = cap_sec_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pps_elapsed_timer.sv
// Randomised scoreboard bench for pps_elapsed_timer. A rule-level reference model predicts
// status, glitch pulses and capture results, and a monitor compares against them.
module tb_pps_elapsed_timer;

    localparam int ET_W = 8;
    localparam int SEC_W = 4;
    localparam int SS = 2;
    localparam int PMIN = 90;
    localparam int PMAX = 110;
    localparam int NCH = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  one_pps = 1'b0;
    logic [NCH-1:0]        capture = '0;
    logic [ET_W-1:0]       elapsed_time;
    logic [SEC_W-1:0]      seconds;
    logic [ET_W-1:0]       pps_period;
    logic                  pps_locked, pps_missing, pps_glitch;
    logic [NCH-1:0]        cap_valid;
    logic [NCH*ET_W-1:0]   cap_time;
    logic [NCH*SEC_W-1:0]  cap_sec;

    pps_elapsed_timer #(
        .ET_WIDTH(ET_W), .SEC_WIDTH(SEC_W), .SYNC_STAGES(SS),
        .PPS_MIN(PMIN), .PPS_MAX(PMAX), .NUM_CH(NCH)
    ) dut (
        .clk_250(clk), .rst(rst), .one_pps(one_pps), .capture(capture),
        .elapsed_time(elapsed_time), .seconds(seconds), .pps_period(pps_period),
        .pps_locked(pps_locked), .pps_missing(pps_missing), .pps_glitch(pps_glitch),
        .cap_valid(cap_valid), .cap_time(cap_time), .cap_sec(cap_sec)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int glitch_seen = 0;
    bit check_en = 1'b0;
    bit cap_rand_en = 1'b1;

    // Reference model state
    typedef enum int {M_UNLOCKED, M_ACQUIRE, M_LOCKED, M_HOLDOVER} mode_t;
    typedef struct { int ch; int t; int s; int cyc; } cap_t;
    mode_t    m_mode = M_UNLOCKED;
    int       m_cnt = 0, m_el = 0, m_period = 0, m_sec = 0, cyc = 0;
    int       pps_hist[$];
    bit       m_prev = 1'b0;
    bit [NCH-1:0] m_cprev = '0;
    cap_t     cap_q[$];
    int       glitch_q[$];

    // One clock of the rules: PPS seen SS samples late, edge = newly high, then priority rules.
    task automatic model_step();
        bit   pedge, lvl, bump, load;
        int   n1;
        cap_t c;
        cyc++;
        if (rst) begin
            m_mode = M_UNLOCKED; m_cnt = 0; m_el = 0; m_period = 0; m_sec = 0;
            m_prev = 1'b0; m_cprev = '0;
            pps_hist.delete();
            for (int k = 0; k < SS; k++) pps_hist.push_back(0);
            return;
        end
        lvl   = (pps_hist[SS-1] != 0);
        pedge = lvl && !m_prev;
        m_prev = lvl;
        pps_hist.push_front(int'(one_pps));
        void'(pps_hist.pop_back());
        for (int ch = 0; ch < NCH; ch++) begin
            if (capture[ch] && !m_cprev[ch]) begin
                c.ch = ch; c.t = m_cnt; c.s = m_sec; c.cyc = cyc;
                cap_q.push_back(c);
            end
        end
        m_cprev = capture;
        m_el = m_cnt;
        n1 = m_cnt + 1;
        bump = 1'b0; load = 1'b0;
        if (m_mode == M_UNLOCKED) begin
            if (pedge) begin load = 1; bump = 1; m_mode = M_ACQUIRE; end
        end else if (m_mode == M_HOLDOVER) begin
            if (pedge) begin load = 1; bump = (n1 >= PMIN); m_mode = M_ACQUIRE; end
            else if (n1 == m_period) begin load = 1; bump = 1; end
        end else begin
            if (pedge && n1 < PMIN) glitch_q.push_back(cyc);
            else if (pedge && n1 <= PMAX) begin
                load = 1; bump = 1; m_period = n1; m_mode = M_LOCKED;
            end else if (n1 == PMAX) begin
                load = 1;
                if (m_mode == M_LOCKED) begin bump = 1; m_mode = M_HOLDOVER; end
                else m_mode = M_UNLOCKED;
            end
        end
        m_cnt = load ? 0 : n1 % (1 << ET_W);
        if (bump) m_sec = (m_sec + 1) % (1 << SEC_W);
    endtask

    initial begin
        for (int k = 0; k < SS; k++) pps_hist.push_back(0);
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: compares status every cycle and pops scoreboard entries as outputs appear.
    initial begin
        cap_t e;
        bit   exp_v, exp_g;
        forever begin
            @(negedge clk);
            if (check_en) begin
                n_checks++;
                if (elapsed_time !== ET_W'(m_el) || seconds !== SEC_W'(m_sec) ||
                    pps_period !== ET_W'(m_period) || pps_locked !== (m_mode == M_LOCKED) ||
                    pps_missing !== (m_mode == M_HOLDOVER)) begin
                    n_errors++;
                    $display("FAIL status cyc=%0d got el=%0d sec=%0d per=%0d lk=%0b ms=%0b required el=%0d sec=%0d per=%0d lk=%0b ms=%0b",
                             cyc, elapsed_time, seconds, pps_period, pps_locked, pps_missing,
                             m_el, m_sec, m_period, m_mode == M_LOCKED, m_mode == M_HOLDOVER);
                end
                exp_g = 1'b0;
                if (glitch_q.size() > 0 && glitch_q[0] <= cyc) begin
                    exp_g = 1'b1;
                    void'(glitch_q.pop_front());
                end
                if (pps_glitch) glitch_seen++;
                if (pps_glitch || exp_g) begin
                    n_checks++;
                    if (pps_glitch !== exp_g) begin
                        n_errors++;
                        $display("FAIL glitch cyc=%0d got %0b required %0b", cyc, pps_glitch, exp_g);
                    end else begin
                        $display("glitch cyc=%0d ok", cyc);
                    end
                end
                for (int ch = 0; ch < NCH; ch++) begin
                    exp_v = (cap_q.size() > 0 && cap_q[0].cyc <= cyc && cap_q[0].ch == ch);
                    if (exp_v) e = cap_q.pop_front();
                    if (cap_valid[ch] || exp_v) begin
                        n_checks++;
                        if (!cap_valid[ch] || !exp_v ||
                            cap_time[ch*ET_W +: ET_W] !== ET_W'(e.t) ||
                            cap_sec[ch*SEC_W +: SEC_W] !== SEC_W'(e.s)) begin
                            n_errors++;
                            $display("FAIL capture ch=%0d cyc=%0d got v=%0b t=%0d s=%0d required v=%0b t=%0d s=%0d",
                                     ch, cyc, cap_valid[ch], cap_time[ch*ET_W +: ET_W],
                                     cap_sec[ch*SEC_W +: SEC_W], exp_v, e.t, e.s);
                        end else begin
                            $display("capture ch=%0d t=%0d s=%0d ok", ch, e.t, e.s);
                        end
                    end
                end
            end
        end
    end

    task automatic check(string name, longint got, longint req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    // Advance one cycle; inputs change only just after a falling edge.
    task automatic tick();
        @(negedge clk);
        if (cap_rand_en) begin
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(0, 31) == 0) capture[ch] = ~capture[ch];
        end
    endtask

    // One PPS interval: pulse of width w, optional 2-cycle glitch pulse at g, optional reset at rst_at.
    task automatic pps_second(int w, int per, int g, int rst_at);
        for (int i = 0; i < per; i++) begin
            one_pps = (i < w) || (g > 0 && i >= g && i < g + 2);
            rst = (i == rst_at);
            tick();
        end
        one_pps = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        int g0;
        repeat (3) tick();
        rst = 1'b0;
        check_en = 1'b1;
        check("reset_elapsed", elapsed_time, 0);
        check("reset_seconds", seconds, 0);

        // Free run in UNLOCKED across the natural counter wrap
        repeat (300) tick();
        check("unlocked_no_lock", pps_locked, 0);

        // First pulse: elapsed reads 0 three cycles after the sampling edge
        one_pps = 1'b1;
        repeat (4) tick();
        check("first_edge_elapsed", elapsed_time, 0);
        check("first_edge_seconds", seconds, 1);
        check("first_edge_not_locked", pps_locked, 0);
        one_pps = 1'b0;
        repeat (96) tick();
        one_pps = 1'b1;
        repeat (4) tick();
        check("second_edge_locked", pps_locked, 1);
        check("second_edge_period", pps_period, 100);
        check("second_edge_seconds", seconds, 2);
        one_pps = 1'b0;
        repeat (96) tick();
        repeat (2) pps_second(3, 100, 0, -1);

        // Extra pulse 40 cycles after an accepted edge
        g0 = glitch_seen;
        pps_second(3, 100, 40, -1);
        check("glitch_once", glitch_seen - g0, 1);
        check("glitch_still_locked", pps_locked, 1);
        check("glitch_period_kept", pps_period, 100);

        // PPS lost: holdover, then restore
        repeat (150) tick();
        check("holdover_missing", pps_missing, 1);
        check("holdover_not_locked", pps_locked, 0);
        repeat (300) tick();
        repeat (3) pps_second(3, 100, 0, -1);
        check("restored_locked", pps_locked, 1);
        check("restored_not_missing", pps_missing, 0);

        // Capture coincident with the accepted-edge load
        cap_rand_en = 1'b0;
        capture = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) pps_second(3, 100, 0, -1);
        one_pps = 1'b1;
        repeat (2) tick();
        capture[2] = 1'b1;
        tick();
        check("collision_valid", cap_valid[2], 1);
        check("collision_time", cap_time[2*ET_W +: ET_W], 99);
        check("collision_sec", cap_sec[2*SEC_W +: SEC_W], 5);
        one_pps = 1'b0;
        tick();
        check("collision_valid_drop", cap_valid[2], 0);
        repeat (94) tick();
        check("held_capture_single", cap_valid[2], 0);
        capture[2] = 1'b0;
        repeat (2) pps_second(3, 100, 0, -1);

        // Reset while a PPS sits in the synchroniser
        one_pps = 1'b1;
        tick();
        rst = 1'b1;
        one_pps = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_elapsed", elapsed_time, 0);
        check("rst_seconds", seconds, 0);
        check("rst_period", pps_period, 0);
        check("rst_locked", pps_locked, 0);
        check("rst_missing", pps_missing, 0);
        check("rst_cap_time", cap_time, 0);
        repeat (200) tick();
        check("rst_pulse_discarded", seconds, 0);

        // Randomised intervals, glitches, gaps and occasional resets
        cap_rand_en = 1'b1;
        for (int s = 0; s < 60; s++) begin
            int r, per, w, g, ra;
            r = $urandom_range(0, 99);
            if (r < 60)      per = $urandom_range(95, 105);
            else if (r < 75) per = $urandom_range(80, 125);
            else if (r < 85) per = $urandom_range(130, 400);
            else             per = $urandom_range(40, 89);
            w  = $urandom_range(1, 5);
            g  = ($urandom_range(0, 4) == 0) ? $urandom_range(20, per - 8) : 0;
            ra = ($urandom_range(0, 29) == 0) ? $urandom_range(0, per - 1) : -1;
            pps_second(w, per, g, ra);
        end

        cap_rand_en = 1'b0;
        capture = '0;
        repeat (5) tick();
        check("scoreboard_drained", cap_q.size() + glitch_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pps_elapsed_timer.md
PPS_ELAPSED_TIMER -- requirements
Module: pps_elapsed_timer

Interface
REQ-001 Parameter ET_WIDTH, default 29, SHALL set the sub-second counter width in bits.
REQ-002 Parameter SEC_WIDTH, default 32, SHALL set the seconds counter width in bits.
REQ-003 Parameter SYNC_STAGES, default 2, minimum 2, SHALL set the number of one_pps synchroniser flops.
REQ-004 Parameter PPS_MIN, default 249_000_000, SHALL be the minimum accepted PPS period in clk_250 cycles.
REQ-005 Parameter PPS_MAX, default 251_000_000, SHALL be the maximum accepted PPS period; it must be less than 2^ET_WIDTH.
REQ-006 Parameter NUM_CH, default 4, SHALL set the number of timestamp capture channels.
REQ-007 clk_250  in  1  SHALL be the single clock; all logic is on its rising edge.
REQ-008 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-009 one_pps  in  1  SHALL be the asynchronous PPS input.
REQ-010 capture  in  NUM_CH  SHALL be the per-channel event strobes, already synchronous to clk_250.
REQ-011 elapsed_time  out  ET_WIDTH  SHALL be the registered sub-second count.
REQ-012 seconds  out  SEC_WIDTH  SHALL be the registered seconds count.
REQ-013 pps_period  out  ET_WIDTH  SHALL be the last accepted in-window period.
REQ-014 pps_locked / pps_missing / pps_glitch  out  1 each  SHALL be the status flags; pps_glitch is a 1-cycle pulse.
REQ-015 cap_valid  out  NUM_CH, cap_time  out  NUM_CH*ET_WIDTH, cap_sec  out  NUM_CH*SEC_WIDTH  SHALL carry the capture results; channel i occupies slice i.

Function
REQ-016 one_pps SHALL pass through SYNC_STAGES flops; pps_edge = last stage high AND previous-cycle value low.
REQ-017 Counter cnt SHALL increment by 1 per cycle unless loaded; elapsed_time = cnt delayed 1 cycle.
REQ-018 For an accepted edge, elapsed_time SHALL read 0 exactly SYNC_STAGES+1 cycles after the first edge sampling one_pps high.
REQ-019 FSM states SHALL be UNLOCKED, ACQUIRE and HOLDOVER, plus LOCKED. pps_locked=1 only in LOCKED; pps_missing=1 only in HOLDOVER.
REQ-020 UNLOCKED: cnt SHALL wrap naturally at 2^ET_WIDTH; any pps_edge -> cnt=0, seconds+1, go to ACQUIRE.
REQ-021 ACQUIRE/LOCKED, pps_edge with cnt+1 < PPS_MIN: edge ignored, pps_glitch pulses, cnt continues, no state change.
REQ-022 ACQUIRE/LOCKED, pps_edge with PPS_MIN <= cnt+1 <= PPS_MAX: cnt=0, seconds+1, pps_period=cnt+1, go to or stay in LOCKED.
REQ-023 ACQUIRE, cnt == PPS_MAX-1 without an edge: cnt=0, go to UNLOCKED; seconds unchanged.
REQ-024 LOCKED, cnt == PPS_MAX-1 without an edge: cnt=0, seconds+1, go to HOLDOVER.
REQ-025 HOLDOVER: cnt SHALL wrap to 0 at pps_period-1 with seconds+1.
REQ-026 HOLDOVER, pps_edge: cnt=0, go to ACQUIRE; seconds+1 only if cnt+1 >= PPS_MIN; never flag a glitch.
REQ-027 A pps_edge coinciding with a timeout or wrap SHALL take priority; the load is applied once and seconds is incremented at most once.
REQ-028 seconds SHALL wrap modulo 2^SEC_WIDTH.
REQ-029 On capture[i] rising, relative to the previous cycle, cap_time[i]/cap_sec[i] SHALL latch the current cnt/seconds (pre-load values if coincident with a load); cap_valid[i] pulses the next cycle.
REQ-030 Channels SHALL be independent; capture held high SHALL yield a single capture.

Reset
REQ-031 rst SHALL clear on the next clk_250 edge: all outputs, cnt, the synchronisers, the edge-detect history and all capture edge histories; state goes to UNLOCKED.
REQ-032 rst asserted mid-operation SHALL override every load and increment that cycle; a PPS already in the synchroniser is discarded.

Verification (sim parameters: PPS_MIN=90, PPS_MAX=110, SYNC_STAGES=2, NUM_CH=4)
REQ-033 First pulse: rst, then PPS at 100-cycle period -> first edge gives ACQUIRE, seconds=1; second edge gives LOCKED, pps_period=100; elapsed_time=0 on cycle 3 after sampling.
REQ-034 Glitch: extra pulse 40 cycles after an accepted edge -> pps_glitch pulses once, cnt unaffected, stays LOCKED.
REQ-035 Holdover: PPS stopped after lock at 100 -> at cnt 109 go to HOLDOVER, seconds+1, then wrap every 100 cycles; PPS restored -> ACQUIRE, then LOCKED.
REQ-036 Capture collision: capture[2] on the same cycle as the accepted-edge load with cnt=99, seconds=5 -> cap_time[2]=99, cap_sec[2]=5, cap_valid[2]=1 next cycle only.
REQ-037 Reset mid-run: rst during LOCKED with a PPS in the synchroniser -> next cycle all outputs 0, UNLOCKED, no edge is accepted from that pulse.
